digit_entry: RTL and testbench
==============================

# digit_entry

Button-driven BCD operand entry for the Basys-3 calculator. Debounces the five push-buttons, keeps a cursor over four decimal digits, and steps the selected digit up or down modulo 10. Its four digit outputs feed the operand-forming stage, which combines them as two 2-digit numbers (c1·10+c2, c3·10+c4). It also exports the cursor position to the display stage.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level (10 ms at 100 MHz); must be ≥2

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- btn_up  in  1  raw button: increment the selected digit
- btn_down  in  1  raw button: decrement the selected digit
- btn_left  in  1  raw button: move the cursor toward c1
- btn_right  in  1  raw button: move the cursor toward c4
- btn_center  in  1  raw button: clear all digits
- c1, c2, c3, c4  out  4 each  BCD digits, always 0..9; c1 is the tens digit of operand 1 and c3 is the tens digit of operand 2
- sel  out  2  cursor: 0 selects c1 and 3 selects c4

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer, then a rising-edge detector. The result is a one-cycle press pulse.
- Debouncer state is a level `db` (reset 0) and a counter `cnt` (reset 0).
  - While the synchronized level equals `db`, `cnt` is cleared to 0.
  - Otherwise `cnt` increments each cycle.
  - When `cnt` reaches DEBOUNCE_CYCLES-1 with a mismatch still present, `db` takes the synchronized level and `cnt` returns to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Pulse priority, evaluated per cycle:
  - 1. center: all digits go to 0 and sel goes to 0. Every other pulse in that cycle is discarded.
  - 2. up/down:
    - up alone: selected digit +1, wrapping 9→0.
    - down alone: selected digit −1, wrapping 0→9.
    - both together: no digit change.
  - 3. left/right, applied independently of up/down in the same cycle:
    - left alone: sel−1, wrapping 0→3.
    - right alone: sel+1, wrapping 3→0.
    - both together: no change.
  - When up/down and left/right fire in the same cycle, the digit update uses the old sel.
- A held button produces exactly one press; there is no auto-repeat. Release produces nothing.
- Reset values: c1..c4 = 0, sel = 0, all synchronizer, debouncer and edge registers = 0.
- Reset mid-press clears everything. A button still held when rst deasserts is treated as a new press and is accepted after debounce.
- Unselected digits never change except on center.

## Timing
- Press latency: the raw input is first sampled high at clock edge k, and the output changes at edge k+DEBOUNCE_CYCLES+3. No other latency is permitted.
- Outputs are registered, with no combinational path from any btn_* input to any output.
- Sustained press rate is at most one press per 2·DEBOUNCE_CYCLES cycles per button, because a release must also debounce.
- rst acts immediately and asynchronously on all registers. Deassertion is synchronized externally.

## Structure
- Shared calculator header/package holds:
  - NUM_DIGITS = 4
  - DIGIT_MAX = 4'd9
  - the sel encodings: SEL_C1 = 0, SEL_C2 = 1, SEL_C3 = 2, SEL_C4 = 3
  - the default DEBOUNCE_CYCLES
- One sub-module, btn_debounce:
  - contains the synchronizer, debouncer and edge detector
  - parameterized by DEBOUNCE_CYCLES
  - output `press` is a one-cycle pulse
  - instantiated five times
- The top level holds the cursor register, the digit registers and the priority logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then press up three times → c1 = 3, others 0, sel = 0. Each step lands exactly 7 edges after its raw rising edge.
- Set sel = 3, then press down once → c4 = 9 (wrap). Press right → sel = 0 (wrap). Press left → sel = 3.
- Press up ten times on c2 → c2 returns to 0; c1, c3, c4 unchanged.
- Bounce btn_up high for 3 cycles, low 1, high 2, then low → no change. Hold high for 4+ cycles → exactly one increment.
- Assert up and down together (identical waveforms) → no digit change. Assert center together with up → all digits 0 and sel = 0.
- Assert rst while btn_up is held mid-debounce → all outputs 0 immediately. With btn_up still held after rst deasserts → c1 = 1 after debounce.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg: shared calculator constants, cursor encoding and BCD step helper.
package digit_entry_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam int DEBOUNCE_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        SEL_C1 = 2'd0,
        SEL_C2 = 2'd1,
        SEL_C3 = 2'd2,
        SEL_C4 = 2'd3
    } sel_t;

    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic up);
        if (up)
            return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
        return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debouncer and registered rising-edge pulse.
module btn_debounce
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_db_q;
    logic          r_press;
    logic          w_mismatch;

    assign w_mismatch = r_sync[1] ^ r_db;
    assign press      = r_press;

    // Pulse is registered so press latency is fixed at sync + debounce + 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_db_q  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_db_q  <= r_db;
            r_press <= r_db & ~r_db_q;
            if (!w_mismatch)
                r_cnt <= '0;
            else if (r_cnt == CNT_LAST) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else
                r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/digit_entry.sv
// digit_entry: button-driven four-digit BCD entry with cursor; center clears, up/down step, left/right move.
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [3:0] c1,
    output logic [3:0] c2,
    output logic [3:0] c3,
    output logic [3:0] c4,
    output logic [1:0] sel
);
    logic [4:0] w_raw;
    logic [4:0] w_press;
    logic [3:0] r_dig [NUM_DIGITS];
    logic [3:0] w_dig [NUM_DIGITS];
    sel_t       r_sel;
    sel_t       w_sel;

    assign w_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (w_raw[i]),
            .press(w_press[i])
        );
    end

    // Digit update indexes with the old cursor, so a same-cycle move never redirects it.
    always_comb begin
        w_dig = r_dig;
        w_sel = r_sel;
        if (w_press[4]) begin
            w_dig = '{default: 4'd0};
            w_sel = SEL_C1;
        end else begin
            if (w_press[0] ^ w_press[1])
                w_dig[r_sel] = digit_step(r_dig[r_sel], w_press[0]);
            if (w_press[2] ^ w_press[3])
                w_sel = w_press[2] ? sel_t'(r_sel - 2'd1) : sel_t'(r_sel + 2'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig <= '{default: 4'd0};
            r_sel <= SEL_C1;
        end else begin
            r_dig <= w_dig;
            r_sel <= w_sel;
        end
    end

    assign c1  = r_dig[0];
    assign c2  = r_dig[1];
    assign c3  = r_dig[2];
    assign c4  = r_dig[3];
    assign sel = r_sel;
endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry: directed plus randomized button stimulus against a window-based behavioural model.
module tb_digit_entry;
    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [4:0] r_btn;
    logic [3:0] c1, c2, c3, c4;
    logic [1:0] sel;

    int n_chk;
    int n_fail;

    int         md [4];
    int         ms;
    logic [31:0] hist [5];
    logic [4:0] acc, q1, q2;

    digit_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (r_btn[0]),
        .btn_down  (r_btn[1]),
        .btn_left  (r_btn[2]),
        .btn_right (r_btn[3]),
        .btn_center(r_btn[4]),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) md[i] = 0;
        ms = 0;
        for (int b = 0; b < 5; b++) hist[b] = '0;
        acc = '0;
        q1  = '0;
        q2  = '0;
    endtask

    // A level is accepted once the last D samples, seen two edges late, all disagree with it;
    // the resulting press reaches the digits two edges after acceptance.
    task automatic model_edge();
        logic [4:0] p;
        logic [D-1:0] win;
        if (rst) return;
        p = q2;
        if (p[4]) begin
            for (int i = 0; i < 4; i++) md[i] = 0;
            ms = 0;
        end else begin
            if (p[0] ^ p[1]) md[ms] = p[0] ? (md[ms] + 1) % 10 : (md[ms] + 9) % 10;
            if (p[2] ^ p[3]) ms = p[2] ? (ms + 3) % 4 : (ms + 1) % 4;
        end
        q2 = q1;
        q1 = '0;
        for (int b = 0; b < 5; b++) begin
            hist[b] = {hist[b][30:0], r_btn[b]};
            win = hist[b][D+1:2];
            if (win == {D{~acc[b]}}) begin
                acc[b] = ~acc[b];
                q1[b]  = acc[b];
            end
        end
    endtask

    function automatic logic [31:0] model_state();
        return {14'd0, 4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3]), 2'(ms)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("state", {14'd0, c1, c2, c3, c4, sel}, model_state());
    endtask

    task automatic press(input logic [4:0] mask);
        r_btn = mask;
        repeat (6) cyc();
        r_btn = '0;
        repeat (8) cyc();
    endtask

    task automatic up_latency();
        logic [3:0] prev;
        int found;
        prev  = c1;
        found = -1;
        r_btn = 5'b00001;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (found < 0 && c1 != prev) found = i - 1;
        end
        r_btn = '0;
        repeat (8) cyc();
        check("up_latency", found, 7);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 check("async_rst", {14'd0, c1, c2, c3, c4, sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        r_btn  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", {14'd0, c1, c2, c3, c4, sel}, 32'd0);
        rst = 1'b0;

        repeat (3) up_latency();
        check("c1_three", c1, 3);
        check("sel_zero", sel, 0);

        press(5'b00100);
        check("sel_wrap_left", sel, 3);
        press(5'b00010);
        check("c4_wrap_down", c4, 9);
        press(5'b01000);
        check("sel_wrap_right", sel, 0);
        press(5'b00100);
        check("sel_left", sel, 3);

        press(5'b01000);
        press(5'b01000);
        check("sel_c2", sel, 1);
        repeat (10) press(5'b00001);
        check("c2_wrap", c2, 0);
        check("c1_kept", c1, 3);
        check("c3_kept", c3, 0);
        check("c4_kept", c4, 9);

        r_btn = 5'b00001; repeat (3) cyc();
        r_btn = 5'b00000; repeat (1) cyc();
        r_btn = 5'b00001; repeat (2) cyc();
        r_btn = 5'b00000; repeat (8) cyc();
        check("bounce_ignored", c2, 0);
        r_btn = 5'b00001; repeat (5) cyc();
        r_btn = 5'b00000; repeat (10) cyc();
        check("hold_one_inc", c2, 1);

        press(5'b00011);
        check("up_down_cancel", c2, 1);
        press(5'b10001);
        check("center_clear", {14'd0, c1, c2, c3, c4, sel}, 32'd0);

        press(5'b00001);
        r_btn = 5'b00001;
        repeat (2) cyc();
        async_reset();
        repeat (12) cyc();
        check("held_after_rst", c1, 1);
        r_btn = '0;
        repeat (8) cyc();

        for (int s = 0; s < 90; s++) begin
            logic [4:0] m;
            m = 5'($urandom);
            if ($urandom_range(0, 5) != 0) m[4] = 1'b0;
            r_btn = m;
            repeat ($urandom_range(1, 12)) cyc();
            if ($urandom_range(0, 40) == 0) async_reset();
        end
        r_btn = '0;
        repeat (10) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
